// File: rtl/axidma_wr_arb.sv
// Round-robin scheduler that shares one AXI write-burst engine between NUM_CH
// channel sequencers, capping in-flight bursts and routing completions in issue order.
module axidma_wr_arb #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_WDTH = 32,
    parameter int MAX_OUTS  = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        cfg_soft_rst,
    input  logic [NUM_CH-1:0]           cfg_ch_en,
    input  logic [NUM_CH-1:0]           ch_wstart_vld,
    input  logic [NUM_CH*ADDR_WDTH-1:0] ch_waddr,
    input  logic [NUM_CH*8-1:0]         ch_wburst_len,
    output logic [NUM_CH-1:0]           ch_wstart_rdy,
    output logic                        m_wstart_vld,
    input  logic                        m_wstart_rdy,
    output logic [ADDR_WDTH-1:0]        m_waddr,
    output logic [7:0]                  m_wburst_len,
    output logic [$clog2(NUM_CH)-1:0]   m_wch_id,
    input  logic                        m_wdone,
    output logic                        arb_busy,
    output logic                        arb_err
);

    localparam int IDW  = $clog2(NUM_CH);
    localparam int PTRW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int CNTW = $clog2(MAX_OUTS + 1);
    localparam logic [CNTW-1:0] OUTS_MAX = CNTW'(MAX_OUTS);

    typedef enum logic {ARB, ISSUE} state_t;

    state_t                 state;
    logic [1:0]             soft_sync;
    logic                   soft_rst;
    logic [NUM_CH-1:0]      pend;
    logic [ADDR_WDTH-1:0]   addr_q [NUM_CH];
    logic [7:0]             len_q  [NUM_CH];
    logic [IDW-1:0]         last_grant;
    logic [IDW-1:0]         fifo   [MAX_OUTS];
    logic [PTRW-1:0]        wr_ptr;
    logic [PTRW-1:0]        rd_ptr;
    logic [CNTW-1:0]        outs_cnt;

    logic                   hs;
    logic [NUM_CH-1:0]      hs_mask;
    logic [NUM_CH-1:0]      elig;
    logic                   sel_found;
    logic [IDW-1:0]         sel_id;
    logic                   can_issue;
    logic                   done_ok;
    logic                   done_err;
    logic                   cap_err;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(MAX_OUTS - 1))
            return '0;
        else
            return p + PTRW'(1);
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            soft_sync <= '0;
        else
            soft_sync <= {soft_sync[0], cfg_soft_rst};
    end

    assign soft_rst = soft_sync[1];

    assign hs       = m_wstart_vld && m_wstart_rdy;
    assign done_ok  = m_wdone && (outs_cnt != '0);
    assign done_err = m_wdone && (outs_cnt == '0);

    always_comb begin
        hs_mask = '0;
        if (hs)
            hs_mask[m_wch_id] = 1'b1;
    end

    // A request landing on its own issue handshake re-arms the channel and is not an overrun.
    assign cap_err = |(ch_wstart_vld & pend & ~hs_mask);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (soft_rst) begin
            pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_wstart_vld[i]) begin
                    pend[i]   <= 1'b1;
                    addr_q[i] <= ch_waddr[i*ADDR_WDTH +: ADDR_WDTH];
                    len_q[i]  <= ch_wburst_len[i*8 +: 8];
                end else if (hs_mask[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        int j;
        j         = 0;
        elig      = pend & cfg_ch_en;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            j = int'(last_grant) + k;
            if (j >= NUM_CH)
                j = j - NUM_CH;
            if (!sel_found && elig[j]) begin
                sel_found = 1'b1;
                sel_id    = j[IDW-1:0];
            end
        end
    end

    assign can_issue = sel_found && (outs_cnt < OUTS_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ARB;
            m_wstart_vld <= 1'b0;
            m_waddr      <= '0;
            m_wburst_len <= '0;
            m_wch_id     <= '0;
            last_grant   <= IDW'(NUM_CH - 1);
        end else if (soft_rst) begin
            state        <= ARB;
            m_wstart_vld <= 1'b0;
            m_waddr      <= '0;
            m_wburst_len <= '0;
            m_wch_id     <= '0;
            last_grant   <= IDW'(NUM_CH - 1);
        end else begin
            case (state)
                ARB: begin
                    if (can_issue) begin
                        m_waddr      <= addr_q[sel_id];
                        m_wburst_len <= len_q[sel_id];
                        m_wch_id     <= sel_id;
                        m_wstart_vld <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        m_wstart_vld <= 1'b0;
                        last_grant   <= m_wch_id;
                        state        <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Completions arrive oldest-first, so the FIFO head always names the owning channel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outs_cnt      <= '0;
            ch_wstart_rdy <= '0;
            for (int i = 0; i < MAX_OUTS; i++)
                fifo[i] <= '0;
        end else if (soft_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outs_cnt      <= '0;
            ch_wstart_rdy <= '0;
            for (int i = 0; i < MAX_OUTS; i++)
                fifo[i] <= '0;
        end else begin
            ch_wstart_rdy <= '0;
            if (hs) begin
                fifo[wr_ptr] <= m_wch_id;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (done_ok) begin
                rd_ptr                      <= ptr_inc(rd_ptr);
                ch_wstart_rdy[fifo[rd_ptr]] <= 1'b1;
            end
            if (hs && !done_ok)
                outs_cnt <= outs_cnt + CNTW'(1);
            else if (!hs && done_ok)
                outs_cnt <= outs_cnt - CNTW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            arb_err <= 1'b0;
        else if (soft_rst)
            arb_err <= 1'b0;
        else if (cap_err || done_err)
            arb_err <= 1'b1;
    end

    assign arb_busy = (|pend) || (state == ISSUE) || (outs_cnt != '0);

endmodule

// File: tb/tb_axidma_wr_arb.sv
// Scoreboard bench for axidma_wr_arb: directed requests push expected issues and
// completions into queues that a negedge monitor pops whenever the DUT presents them.
module tb_axidma_wr_arb;

    localparam int NUM_CH    = 5;
    localparam int ADDR_WDTH = 32;
    localparam int MAX_OUTS  = 4;
    localparam int IDW       = $clog2(NUM_CH);

    logic                        sys_clk = 1'b0;
    logic                        sys_rst_n;
    logic                        cfg_soft_rst;
    logic [NUM_CH-1:0]           cfg_ch_en;
    logic [NUM_CH-1:0]           ch_wstart_vld;
    logic [NUM_CH*ADDR_WDTH-1:0] ch_waddr;
    logic [NUM_CH*8-1:0]         ch_wburst_len;
    logic [NUM_CH-1:0]           ch_wstart_rdy;
    logic                        m_wstart_vld;
    logic                        m_wstart_rdy;
    logic [ADDR_WDTH-1:0]        m_waddr;
    logic [7:0]                  m_wburst_len;
    logic [IDW-1:0]              m_wch_id;
    logic                        m_wdone;
    logic                        arb_busy;
    logic                        arb_err;

    typedef struct {
        logic [IDW-1:0]       id;
        logic [ADDR_WDTH-1:0] addr;
        logic [7:0]           len;
    } issue_t;

    issue_t exp_issue[$];
    int     exp_cmpl[$];

    int compared      = 0;
    int mismatched    = 0;
    int hs_count      = 0;
    int rdy_count     = 0;
    int last_hs_cycle = 0;
    int cycle         = 0;

    axidma_wr_arb #(
        .NUM_CH    (NUM_CH),
        .ADDR_WDTH (ADDR_WDTH),
        .MAX_OUTS  (MAX_OUTS)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cfg_soft_rst  (cfg_soft_rst),
        .cfg_ch_en     (cfg_ch_en),
        .ch_wstart_vld (ch_wstart_vld),
        .ch_waddr      (ch_waddr),
        .ch_wburst_len (ch_wburst_len),
        .ch_wstart_rdy (ch_wstart_rdy),
        .m_wstart_vld  (m_wstart_vld),
        .m_wstart_rdy  (m_wstart_rdy),
        .m_waddr       (m_waddr),
        .m_wburst_len  (m_wburst_len),
        .m_wch_id      (m_wch_id),
        .m_wdone       (m_wdone),
        .arb_busy      (arb_busy),
        .arb_err       (arb_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every handshake and every completion pulse must match the queue head.
    always @(negedge sys_clk) begin
        issue_t ei;
        int     ec;
        if (sys_rst_n) begin
            if (m_wstart_vld && m_wstart_rdy) begin
                hs_count++;
                last_hs_cycle = cycle;
                if (exp_issue.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL issue_unexpected: got ch %0d addr 0x%0h, want no issue (cycle %0d)",
                             m_wch_id, m_waddr, cycle);
                end else begin
                    ei = exp_issue.pop_front();
                    checkOutput("issue_payload", {m_wch_id, m_waddr, m_wburst_len}, {ei.id, ei.addr, ei.len});
                end
            end
            if (ch_wstart_rdy != '0) begin
                rdy_count++;
                if (exp_cmpl.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL cmpl_unexpected: got ch_wstart_rdy 0x%0h, want 0 (cycle %0d)",
                             ch_wstart_rdy, cycle);
                end else begin
                    ec = exp_cmpl.pop_front();
                    checkOutput("cmpl_channel", 64'(ch_wstart_rdy), 64'd1 << ec);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic setReq(input int ch, input logic [31:0] addr, input logic [7:0] len, input bit expect_issue);
        issue_t e;
        ch_wstart_vld[ch]                   = 1'b1;
        ch_waddr[ch*ADDR_WDTH +: ADDR_WDTH] = addr;
        ch_wburst_len[ch*8 +: 8]            = len;
        if (expect_issue) begin
            e.id   = IDW'(ch);
            e.addr = addr;
            e.len  = len;
            exp_issue.push_back(e);
            exp_cmpl.push_back(ch);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [31:0] addr, input logic [7:0] len, input bit expect_issue);
        setReq(ch, addr, len, expect_issue);
        tick(1);
        ch_wstart_vld = '0;
    endtask

    task automatic pulseDone();
        m_wdone = 1'b1;
        tick(1);
        m_wdone = 1'b0;
    endtask

    task automatic waitHs(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (hs_count < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, 64'(hs_count), 64'(target));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int req_cycle;
        int rc;
        int n;
        int bad;

        sys_rst_n     = 1'b0;
        cfg_soft_rst  = 1'b0;
        cfg_ch_en     = '1;
        ch_wstart_vld = '0;
        ch_waddr      = '0;
        ch_wburst_len = '0;
        m_wstart_rdy  = 1'b0;
        m_wdone       = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);

        $display("[TB] reset state");
        checkOutput("rst_m_vld", m_wstart_vld, 0);
        checkOutput("rst_busy", arb_busy, 0);
        checkOutput("rst_err", arb_err, 0);
        checkOutput("rst_cmpl", ch_wstart_rdy, 0);
        checkOutput("rst_payload", {m_wch_id, m_waddr, m_wburst_len}, 0);

        $display("[TB] round robin and outstanding limit");
        m_wstart_rdy = 1'b1;
        base = hs_count;
        for (int i = 0; i < 4; i++)
            setReq(i, 32'h100 * (i + 1), 8'(i), 1'b1);
        tick(1);
        ch_wstart_vld = '0;
        waitHs(base + 1, 20, "rr_first_grant");
        applyStimulus(0, 32'h0000_A000, 8'h20, 1'b1);
        waitHs(base + 4, 40, "rr_four_grants");
        tick(10);
        checkOutput("rr_limit_count", 64'(hs_count - base), 4);
        checkOutput("rr_limit_vld_low", m_wstart_vld, 0);
        checkOutput("rr_limit_busy", arb_busy, 1);
        pulseDone();
        waitHs(base + 5, 20, "rr_ch0_after_ch3");
        repeat (4) begin
            tick(2);
            pulseDone();
        end
        tick(3);
        checkOutput("rr_idle_busy", arb_busy, 0);

        $display("[TB] single request latency");
        base      = hs_count;
        req_cycle = cycle;
        applyStimulus(1, 32'h0000_1000, 8'd15, 1'b1);
        waitHs(base + 1, 20, "single_issue");
        checkOutput("single_latency", 64'(last_hs_cycle - req_cycle), 2);
        tick(5);
        checkOutput("single_busy", arb_busy, 1);
        checkOutput("single_no_early_rdy", ch_wstart_rdy, 0);
        pulseDone();
        checkOutput("single_rdy_pulse", ch_wstart_rdy, 5'b00010);
        checkOutput("single_busy_fall", arb_busy, 0);
        tick(1);
        checkOutput("single_rdy_width", ch_wstart_rdy, 0);
        checkOutput("single_err", arb_err, 0);

        $display("[TB] five requesters against MAX_OUTS");
        base = hs_count;
        setReq(2, 32'h2000_0000, 8'h02, 1'b1);
        setReq(3, 32'h3000_0000, 8'h03, 1'b1);
        setReq(4, 32'h4000_0000, 8'h04, 1'b1);
        setReq(0, 32'h0500_0000, 8'h05, 1'b1);
        setReq(1, 32'h1000_0000, 8'h01, 1'b1);
        tick(1);
        ch_wstart_vld = '0;
        waitHs(base + 4, 40, "limit_four_grants");
        tick(10);
        checkOutput("limit_stuck_at_four", 64'(hs_count - base), 4);
        checkOutput("limit_vld_low", m_wstart_vld, 0);
        pulseDone();
        waitHs(base + 5, 20, "limit_fifth_grant");
        repeat (4) begin
            tick(2);
            pulseDone();
        end
        tick(3);
        checkOutput("limit_idle_busy", arb_busy, 0);

        $display("[TB] backpressure and collision");
        base = hs_count;
        applyStimulus(4, 32'h4444_0000, 8'h44, 1'b1);
        waitHs(base + 1, 20, "bp_first_issue");
        m_wstart_rdy = 1'b0;
        applyStimulus(3, 32'h3333_0000, 8'h7F, 1'b1);
        n = 0;
        while (!m_wstart_vld && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("bp_vld_rise", m_wstart_vld, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)
                cfg_ch_en[3] = 1'b0;
            if ({m_wstart_vld, m_wch_id, m_waddr, m_wburst_len} !== {1'b1, IDW'(3), 32'h3333_0000, 8'h7F})
                bad++;
            tick(1);
        end
        checkOutput("bp_payload_stable", 64'(bad), 0);
        checkOutput("bp_no_accept", 64'(hs_count - base), 1);
        cfg_ch_en    = '1;
        rc           = rdy_count;
        m_wstart_rdy = 1'b1;
        m_wdone      = 1'b1;
        tick(1);
        m_wdone      = 1'b0;
        m_wstart_rdy = 1'b0;
        checkOutput("coll_rdy_ch4", ch_wstart_rdy, 5'b10000);
        checkOutput("coll_accept", 64'(hs_count - base), 2);
        tick(2);
        pulseDone();
        tick(2);
        checkOutput("coll_err_clean", arb_err, 0);
        checkOutput("coll_rdy_count", 64'(rdy_count - rc), 2);
        pulseDone();
        tick(2);
        checkOutput("idle_done_no_rdy", 64'(rdy_count - rc), 2);
        checkOutput("idle_done_err", arb_err, 1);

        cfg_soft_rst = 1'b1;
        tick(4);
        cfg_soft_rst = 1'b0;
        tick(3);
        checkOutput("srst_err_cleared", arb_err, 0);

        $display("[TB] overrun on a disabled channel");
        cfg_ch_en    = 5'b11011;
        m_wstart_rdy = 1'b1;
        base         = hs_count;
        applyStimulus(2, 32'h2222_0000, 8'h03, 1'b0);
        tick(2);
        checkOutput("dbl_first_no_err", arb_err, 0);
        applyStimulus(2, 32'h2BBB_0000, 8'h09, 1'b1);
        tick(2);
        checkOutput("dbl_err_set", arb_err, 1);
        tick(8);
        checkOutput("dis_no_grant", 64'(hs_count - base), 0);
        checkOutput("dis_busy", arb_busy, 1);
        cfg_ch_en = '1;
        waitHs(base + 1, 20, "dis_reenable_issue");
        tick(2);
        pulseDone();
        tick(3);

        $display("[TB] soft reset with bursts outstanding");
        cfg_ch_en = 5'b01111;
        base      = hs_count;
        setReq(0, 32'h0A00_0000, 8'h01, 1'b1);
        setReq(1, 32'h0B00_0000, 8'h02, 1'b1);
        setReq(2, 32'h0C00_0000, 8'h03, 1'b1);
        setReq(4, 32'h0E00_0000, 8'h05, 1'b0);
        tick(1);
        ch_wstart_vld = '0;
        waitHs(base + 3, 30, "srst_three_issued");
        checkOutput("srst_busy_before", arb_busy, 1);
        cfg_soft_rst = 1'b1;
        tick(4);
        checkOutput("srst_vld_low", m_wstart_vld, 0);
        checkOutput("srst_busy_low", arb_busy, 0);
        checkOutput("srst_err_low", arb_err, 0);
        exp_cmpl.delete();
        cfg_soft_rst = 1'b0;
        tick(3);
        cfg_ch_en = '1;
        rc = rdy_count;
        pulseDone();
        tick(2);
        pulseDone();
        tick(3);
        checkOutput("srst_no_rdy", 64'(rdy_count - rc), 0);
        checkOutput("srst_err_again", arb_err, 1);
        checkOutput("srst_no_regrant", 64'(hs_count - base), 3);
        checkOutput("srst_idle_busy", arb_busy, 0);

        checkOutput("issue_queue_drained", 64'(exp_issue.size()), 0);
        checkOutput("cmpl_queue_drained", 64'(exp_cmpl.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
